// File: rtl/apu_pkg.sv
// Shared constants for the APU length counter bank: length table and timing.
package apu_pkg;

    localparam int LEN_W               = 8;
    localparam int LEN_IDX_W           = 5;
    localparam int NES_CPU_HZ          = 1789773;
    localparam int HALF_FRAME_DIV_NTSC = 14915;

    // Entry 31 sits in the MSBs so LEN_TABLE[idx] reads naturally.
    localparam logic [31:0][LEN_W-1:0] LEN_TABLE = {
        8'd30,  8'd32,  8'd28,  8'd16,  8'd26,  8'd72,  8'd24,  8'd192,
        8'd22,  8'd96,  8'd20,  8'd48,  8'd18,  8'd24,  8'd16,  8'd12,
        8'd14,  8'd26,  8'd12,  8'd14,  8'd10,  8'd60,  8'd8,   8'd160,
        8'd6,   8'd80,  8'd4,   8'd40,  8'd2,   8'd20,  8'd254, 8'd10
    };

    function automatic logic [LEN_W-1:0] len_lookup(input logic [LEN_IDX_W-1:0] idx);
        return LEN_TABLE[idx];
    endfunction

endpackage

// File: rtl/apu_length_counter_bank_if.sv
// Length-load write bus driven by the register decode into the counter bank.
interface apu_length_counter_bank_if
    import apu_pkg::*;
#(
    parameter int CH_IDX_W = 2
);
    logic                 wr_en;
    logic [CH_IDX_W-1:0]  wr_ch;
    logic [LEN_IDX_W-1:0] wr_len_idx;

    modport master (output wr_en, wr_ch, wr_len_idx);
    modport slave  (input  wr_en, wr_ch, wr_len_idx);
endinterface

// File: rtl/apu_tick_divider.sv
// Free-running half-frame divider; registered one-cycle tick every DIV clocks.
// Not built when APU_LC_EXT_TICK_EN is defined.
`ifndef APU_LC_EXT_TICK_EN
module apu_tick_divider #(
    parameter int DIV = 14915
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;
    logic          at_end;

    assign at_end = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= at_end;
            cnt  <= at_end ? '0 : cnt + CW'(1);
        end
    end
endmodule
`endif

// File: rtl/apu_length_counter_bank.sv
// Bank of NES-APU length counters gating each channel's sample to the mixer.
// Define APU_LC_EXT_TICK_EN to clock the counters from an external ext_tick.
module apu_length_counter_bank
    import apu_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int SAMPLE_W       = 4,
    parameter int HALF_FRAME_DIV = HALF_FRAME_DIV_NTSC,
    parameter int CH_IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    apu_length_counter_bank_if.slave     wr,
`ifdef APU_LC_EXT_TICK_EN
    input  logic                         ext_tick,
`endif
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [NUM_CH-1:0]            ch_halt,
    input  logic [NUM_CH*SAMPLE_W-1:0]   snd_in,
    output logic [NUM_CH*SAMPLE_W-1:0]   snd_out,
    output logic [NUM_CH-1:0]            status,
    output logic                         half_frame_tick
);
    logic                               tick;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]    snd_in_v;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]    snd_out_q;

    assign snd_in_v = snd_in;
    assign snd_out  = snd_out_q;

`ifdef APU_LC_EXT_TICK_EN
    // Counters consume ext_tick the cycle it arrives; the echo lags by one.
    logic ext_tick_q;

    always_ff @(posedge clk) begin
        if (reset) ext_tick_q <= 1'b0;
        else       ext_tick_q <= ext_tick;
    end

    assign tick            = ext_tick;
    assign half_frame_tick = ext_tick_q;
`else
    logic div_tick;

    apu_tick_divider #(.DIV(HALF_FRAME_DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .tick  (div_tick)
    );

    assign tick            = div_tick;
    assign half_frame_tick = div_tick;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [LEN_W-1:0] cnt;
        logic             wr_hit;

        // Out-of-range wr_ch never matches any channel, so such writes drop.
        assign wr_hit = wr.wr_en && (wr.wr_ch == CH_IDX_W'(c));

        always_ff @(posedge clk) begin
            if (reset || !ch_enable[c])
                cnt <= '0;
            else if (wr_hit)
                cnt <= len_lookup(wr.wr_len_idx);
            else if (tick && !ch_halt[c] && cnt != '0)
                cnt <= cnt - LEN_W'(1);
        end

        assign status[c] = (cnt != '0);
    end

    // Halt only freezes the count; gating follows the counter alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            snd_out_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++)
                snd_out_q[c] <= status[c] ? snd_in_v[c] : '0;
        end
    end
endmodule

// File: tb/tb_apu_length_counter_bank.sv
// Randomised and directed bench for apu_length_counter_bank against a count-based model.
module tb_apu_length_counter_bank;
    localparam int NUM_CH = 6;
    localparam int SW     = 4;
    localparam int DIV    = 4;
    localparam int IW     = 3;
    localparam int NW     = NUM_CH * SW;
`ifdef APU_LC_EXT_TICK_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_CH-1:0] ch_enable = '0;
    logic [NUM_CH-1:0] ch_halt = '0;
    logic [NW-1:0]     snd_in = '0;
    logic [NW-1:0]     snd_out;
    logic [NUM_CH-1:0] status;
    logic              half_frame_tick;
`ifdef APU_LC_EXT_TICK_EN
    logic              ext_tick = 1'b0;
`endif

    apu_length_counter_bank_if #(.CH_IDX_W(IW)) bus();

    apu_length_counter_bank #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SW), .HALF_FRAME_DIV(DIV), .CH_IDX_W(IW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .wr              (bus),
`ifdef APU_LC_EXT_TICK_EN
        .ext_tick        (ext_tick),
`endif
        .ch_enable       (ch_enable),
        .ch_halt         (ch_halt),
        .snd_in          (snd_in),
        .snd_out         (snd_out),
        .status          (status),
        .half_frame_tick (half_frame_tick)
    );

    always #5 clk = ~clk;

    int len_tab[32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                        12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

    // Model state: remaining length per channel, gated output, visible tick, edges since reset.
    int            m_cnt[NUM_CH];
    logic [NW-1:0] m_out = '0;
    logic          m_hft = 1'b0;
    int            m_k = 0;
    logic          last_tk = 1'b0;
    bit            ext_rand = 1'b0;
    int            n_vec = 0;
    int            n_err = 0;

    function automatic logic [NUM_CH-1:0] exp_st();
        logic [NUM_CH-1:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c] = (m_cnt[c] != 0);
        return r;
    endfunction

    function automatic logic tick_pending();
`ifdef APU_LC_EXT_TICK_EN
        return (m_k > 0) && (m_k % DIV == 0);
`else
        return m_hft;
`endif
    endfunction

    // One clock: the model applies the spec rules to the inputs seen at the edge.
    task automatic step();
        logic tk;
`ifdef APU_LC_EXT_TICK_EN
        ext_tick = ext_rand ? ($urandom_range(4) == 0) : tick_pending();
`endif
        @(posedge clk);
`ifdef APU_LC_EXT_TICK_EN
        tk = ext_tick;
`else
        tk = m_hft;
`endif
        last_tk = tk && !reset;
        for (int c = 0; c < NUM_CH; c++) begin
            m_out[c*SW +: SW] = (!reset && m_cnt[c] != 0) ? snd_in[c*SW +: SW] : '0;
            if (reset || !ch_enable[c])                        m_cnt[c] = 0;
            else if (bus.wr_en && int'(bus.wr_ch) == c)        m_cnt[c] = len_tab[bus.wr_len_idx];
            else if (tk && !ch_halt[c] && m_cnt[c] > 0)        m_cnt[c] = m_cnt[c] - 1;
        end
        if (reset) begin
            m_k = 0;
            m_hft = 1'b0;
        end else begin
            m_k++;
`ifdef APU_LC_EXT_TICK_EN
            m_hft = ext_tick;
`else
            m_hft = (m_k % DIV == 0);
`endif
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.wr_en = 1'b0;
        step();
        step();
        reset = 1'b0;
        ch_enable = '1;
        ch_halt = '0;
    endtask

    task automatic load(input int ch, input int idx);
        bus.wr_en = 1'b1;
        bus.wr_ch = IW'(ch);
        bus.wr_len_idx = 5'(idx);
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ch_enable = NUM_CH'($urandom);
            snd_in = NW'($urandom);
            bus.wr_en = 1'b1;
            bus.wr_ch = IW'($urandom);
            bus.wr_len_idx = 5'($urandom);
            step();
            n_vec++;
            if ({half_frame_tick, status, snd_out} !== '0) begin
                n_err++;
                $display("FAIL reset_state: got hft=%b st=%b out=%h want all zero", half_frame_tick, status, snd_out);
            end
        end
        bus.wr_en = 1'b0;
        reset = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!half_frame_tick && n < 4 * DIV);
        n_vec++;
        if (n != DIV + LAG) begin
            n_err++;
            $display("FAIL first_tick: got tick after %0d cycles want %0d", n, DIV + LAG);
        end
    endtask

    task automatic test_load();
        do_reset();
        snd_in = NW'($urandom);
        snd_in[3:0] = 4'hA;
        load(0, 1);
        n_vec++;
        if (status[0] !== 1'b1 || {half_frame_tick, status, snd_out} !== {m_hft, exp_st(), m_out}) begin
            n_err++;
            $display("FAIL load_status: got st=%b out=%h want st=%b out=%h", status, snd_out, exp_st(), m_out);
        end
        step();
        n_vec++;
        if (snd_out[3:0] !== 4'hA || snd_out !== m_out) begin
            n_err++;
            $display("FAIL load_out: got %h want %h (ch0 a)", snd_out, m_out);
        end
    endtask

    task automatic test_expire();
        int fall;
        do_reset();
        snd_in = '0;
        snd_in[7:4] = 4'h5;
        load(1, 3);
        fall = -1;
        for (int i = 2; i <= 20; i++) begin
            step();
            n_vec++;
            if ({half_frame_tick, status, snd_out} !== {m_hft, exp_st(), m_out}) begin
                n_err++;
                $display("FAIL expire_vec: cyc %0d got %h want %h", i,
                         {half_frame_tick, status, snd_out}, {m_hft, exp_st(), m_out});
            end
            if (fall < 0 && !status[1]) begin
                fall = i;
                n_vec++;
                if (snd_out[7:4] !== 4'h5) begin
                    n_err++;
                    $display("FAIL expire_last_out: got %h want 5", snd_out[7:4]);
                end
            end else if (fall > 0 && i == fall + 1) begin
                n_vec++;
                if (snd_out[7:4] !== 4'h0) begin
                    n_err++;
                    $display("FAIL expire_gate: got %h want 0", snd_out[7:4]);
                end
            end
        end
        n_vec++;
        if (fall != 2 * DIV + 1) begin
            n_err++;
            $display("FAIL expire_cycle: got %0d want %0d", fall, 2 * DIV + 1);
        end
    endtask

    task automatic test_halt();
        int ticks;
        bit done;
        do_reset();
        ch_halt = 6'b000100;
        snd_in = '0;
        snd_in[11:8] = 4'h7;
        load(2, 0);
        for (int i = 0; i < 20 * DIV + 2; i++) begin
            step();
            n_vec++;
            if ({half_frame_tick, status, snd_out} !== {m_hft, exp_st(), m_out}) begin
                n_err++;
                $display("FAIL halt_vec: got %h want %h", {half_frame_tick, status, snd_out}, {m_hft, exp_st(), m_out});
            end
        end
        n_vec++;
        if (status[2] !== 1'b1 || snd_out[11:8] !== 4'h7) begin
            n_err++;
            $display("FAIL halt_hold: got st=%b out=%h want st=1 out=7", status[2], snd_out[11:8]);
        end
        ch_halt = '0;
        ticks = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            if (last_tk) ticks++;
            if (!status[2]) done = 1'b1;
        end
        n_vec++;
        if (!done || ticks != 10) begin
            n_err++;
            $display("FAIL halt_resume: got %0d ticks (expired=%0d) want 10", ticks, done);
        end
    endtask

    task automatic test_collision();
        int ticks;
        bit done;
        do_reset();
        for (int i = 0; i < 4 * DIV && !tick_pending(); i++) step();
        load(3, 5);
        n_vec++;
        if (!last_tk || status[3] !== 1'b1) begin
            n_err++;
            $display("FAIL collide_load: got st=%b tick=%b want st=1 tick=1", status[3], last_tk);
        end
        ticks = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            if (last_tk) ticks++;
            if (!status[3]) done = 1'b1;
        end
        n_vec++;
        if (!done || ticks != 4) begin
            n_err++;
            $display("FAIL collide_len: got %0d ticks (expired=%0d) want 4", ticks, done);
        end
    endtask

    task automatic test_disable();
        do_reset();
        snd_in = NW'($urandom) | 24'h1;
        load(0, 6);
        repeat (3) step();
        ch_enable[0] = 1'b0;
        step();
        n_vec++;
        if (status[0] !== 1'b0 || status !== exp_st()) begin
            n_err++;
            $display("FAIL disable_clear: got st=%b want %b", status, exp_st());
        end
        load(0, 1);
        n_vec++;
        if (status[0] !== 1'b0 || status !== exp_st()) begin
            n_err++;
            $display("FAIL disable_write: got st=%b want %b", status, exp_st());
        end
        step();
        n_vec++;
        if (snd_out[3:0] !== 4'h0) begin
            n_err++;
            $display("FAIL disable_out: got %h want 0", snd_out[3:0]);
        end
        ch_enable = '1;
    endtask

    task automatic test_bad_ch();
        do_reset();
        for (int ch = NUM_CH; ch < 8; ch++) begin
            load(ch, 1);
            n_vec++;
            if (status !== '0) begin
                n_err++;
                $display("FAIL bad_ch%0d: got st=%b want 000000", ch, status);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        load(4, 8);
        repeat (DIV + 1) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_vec++;
        if (status !== '0 || snd_out !== '0) begin
            n_err++;
            $display("FAIL midreset_clear: got st=%b out=%h want 0", status, snd_out);
        end
        n = 0;
        do begin
            step();
            n++;
        end while (!half_frame_tick && n < 4 * DIV);
        n_vec++;
        if (n != DIV + LAG) begin
            n_err++;
            $display("FAIL midreset_phase: got tick after %0d cycles want %0d", n, DIV + LAG);
        end
    endtask

    task automatic test_random();
        int idx;
        do_reset();
        ext_rand = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(999) == 0);
            bus.wr_en = ($urandom_range(5) == 0);
            bus.wr_ch = IW'($urandom_range(7));
            // Lean on short lengths so channels expire often.
            idx = ($urandom_range(3) == 0) ? $urandom_range(31) : 3 + 2 * $urandom_range(2);
            bus.wr_len_idx = 5'(idx);
            if ($urandom_range(99) == 0) ch_enable[$urandom_range(NUM_CH - 1)] ^= 1'b1;
            if ($urandom_range(39) == 0) ch_halt[$urandom_range(NUM_CH - 1)] ^= 1'b1;
            snd_in = NW'($urandom);
            step();
            n_vec++;
            if ({half_frame_tick, status, snd_out} !== {m_hft, exp_st(), m_out}) begin
                n_err++;
                $display("FAIL random_vec: iter %0d got %h want %h", i,
                         {half_frame_tick, status, snd_out}, {m_hft, exp_st(), m_out});
            end
        end
        ext_rand = 1'b0;
        bus.wr_en = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
        bus.wr_en = 1'b0;
        bus.wr_ch = '0;
        bus.wr_len_idx = '0;
        @(negedge clk);
        test_reset();
        test_load();
        test_expire();
        test_halt();
        test_collision();
        test_disable();
        test_bad_ch();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/apu_length_counter_bank.md
Name: apu_length_counter_bank

Overview:
- Parametrised bank of NES-APU-style length counters, one per sound channel. Each counter is loaded from the 32-entry length table, decremented on half-frame ticks, and gates its channel's sample to zero when it expires.
- Sits between the channel generators (square/triangle/noise) and the mixer.
- Supplies the per-channel status bits read back through the $4015-equivalent status register.
- Replaces per-channel ad-hoc counters with a single clocked block that has a proper tick source and defined write/tick priority.

Parameters:
- NUM_CH, 4, number of channels (≥1).
- SAMPLE_W, 4, width of each channel sample.
- HALF_FRAME_DIV, 14915, clk cycles per half-frame tick (≥2); 1.789773 MHz / 120 Hz.
- CH_IDX_W, $clog2(NUM_CH) (min 1), width of channel select.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  length-load strobe; one cycle, one channel.
- wr_ch  in  CH_IDX_W  channel targeted by wr_en.
- wr_len_idx  in  5  length-table index (register bits 7:3).
- ch_enable  in  NUM_CH  per-channel enable ($4015 write bits), level.
- ch_halt  in  NUM_CH  per-channel halt / length-disable, level.
- snd_in  in  NUM_CH*SAMPLE_W  packed channel samples; ch0 in the LSBs.
- snd_out  out  NUM_CH*SAMPLE_W  gated samples, registered.
- status  out  NUM_CH  1 = counter non-zero.
- half_frame_tick  out  1  one-cycle pulse when counters clock.

Behaviour:
- Reset (synchronous, active-high):
  - All counters = 0.
  - Divider = 0.
  - snd_out = 0, status = 0, half_frame_tick = 0.
- Counters:
  - One 8-bit counter per channel.
  - Length table, index 0..31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Divider:
  - Counts 0..HALF_FRAME_DIV-1, then wraps to 0.
  - half_frame_tick is registered and high for exactly the cycle after the divider reaches HALF_FRAME_DIV-1.
  - Period = HALF_FRAME_DIV cycles.
  - First tick occurs HALF_FRAME_DIV cycles after reset deasserts.
- Per-channel next-state, in priority order:
  1. ch_enable[c]=0 → counter ← 0. A load to a disabled channel is ignored.
  2. wr_en && wr_ch==c → counter ← table[wr_len_idx]. A load wins over a same-cycle tick: no decrement that cycle.
  3. Tick && !ch_halt[c] && counter!=0 → counter ← counter-1.
  4. Otherwise hold.
- No wrap-around: a counter at 0 stays at 0 on tick.
- wr_ch ≥ NUM_CH: write ignored.
- status[c] = (counter[c]!=0), taken combinationally from the counter register. A load is visible on status the cycle after wr_en.
- snd_out:
  - Slice c ← (counter[c]!=0) ? snd_in slice c : 0, registered.
  - Latency: 1 cycle from snd_in; 1 cycle from the counter change.
  - ch_halt does not gate output; it only freezes the count.
- Reset mid-operation discards all counts and restarts the divider phase.

Optional Feature:
- Macro: APU_LC_EXT_TICK_EN.
- Defined:
  - Adds input ext_tick (1 bit).
  - The internal divider is removed and HALF_FRAME_DIV is unused.
  - Counters clock on ext_tick, for use with an external frame sequencer (4-/5-step modes).
  - half_frame_tick = ext_tick delayed one cycle; reset value 0.
- Undefined: internal divider as described above; no ext_tick port.

Decomposition:
- Package apu_pkg:
  - LEN_TABLE constant (32×8).
  - Function len_lookup(idx).
  - Localparams LEN_W=8, LEN_IDX_W=5, NES_CPU_HZ, HALF_FRAME_DIV_NTSC=14915.
- Sub-module apu_tick_divider:
  - Parameter DIV.
  - Ports clk, reset, tick.
  - Excluded from compilation when APU_LC_EXT_TICK_EN is defined.
- Counters: generate loop over NUM_CH in the top module.

Test Plan:
1. Reset, then ch_enable=4'hF, write ch0 idx 1, snd_in ch0=4'hA → next cycle counter0=254 and status[0]=1; snd_out ch0=4'hA one cycle later.
2. HALF_FRAME_DIV=4, ch1 loaded idx 3 (=2), halt=0 → ticks at cycles 4 and 8 after reset; status[1] falls after the second tick; snd_out ch1 is 0 the following cycle.
3. ch2 loaded idx 0 (=10), ch_halt[2]=1, 20 ticks → counter stays 10 and output passes through; releasing halt resumes the decrement.
4. Write ch3 idx 5 on the same cycle as a tick → counter=4 with no decrement; the next tick gives 3.
5. ch_enable[0]=0 while counter0=80 → counter0=0 next cycle; a later write to ch0 with enable still low leaves 0.
6. APU_LC_EXT_TICK_EN defined: 3 ext_tick pulses on a counter loaded with idx 7 (=6) → counter=3; half_frame_tick echoes each pulse 1 cycle later; NUM_CH=6 build with wr_ch=7 → no change.
